// File: rtl/l2cache_control_if.sv
// Control/handshake bundle between the L2 sequencer, the L1 arbiter, the
// cacheline adaptor and the L2 datapath. The slave modport is the sequencer's view.
interface l2cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;
  logic hit_any;
  logic dirty;
  logic load_data;
  logic valid_in;
  logic load_waddr;

  modport master (
    output mem_read, mem_write, pmem_resp, hit_any, dirty,
    input  mem_resp, pmem_read, pmem_write, load_data, valid_in, load_waddr
  );

  modport slave (
    input  mem_read, mem_write, pmem_resp, hit_any, dirty,
    output mem_resp, pmem_read, pmem_write, load_data, valid_in, load_waddr
  );
endinterface

// File: rtl/l2cache_control.sv
// Sequencing FSM for the 2-way, 8-set L2 cache: hit/miss, dirty writeback, fill.
// Optional performance counters are enabled with `define L2CACHE_PERF_EN.
module l2cache_control
`ifdef L2CACHE_PERF_EN
  #(parameter int CNT_W = 32)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  l2cache_control_if.slave   bus
`ifdef L2CACHE_PERF_EN
  ,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count,
  output logic [CNT_W-1:0]   wb_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    TAG_CHECK,
    WRITEBACK,
    FILL,
    DONE
  } state_t;

  state_t state;
  logic   req;

  // A simultaneous read and write is handled as a write by the datapath.
  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:      if (req) state <= TAG_CHECK;
        TAG_CHECK: begin
          if (!req)             state <= IDLE;
          else if (bus.hit_any) state <= DONE;
          else if (bus.dirty)   state <= WRITEBACK;
          else                  state <= FILL;
        end
        WRITEBACK: if (bus.pmem_resp) state <= FILL;
        FILL:      if (bus.pmem_resp) state <= TAG_CHECK;
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // mem_resp and load_data are Mealy so the hit and the fill land in the same cycle.
  always_comb begin
    bus.mem_resp   = (state == TAG_CHECK) && req && bus.hit_any;
    bus.pmem_write = (state == WRITEBACK);
    bus.load_waddr = (state == WRITEBACK);
    bus.pmem_read  = (state == FILL);
    bus.load_data  = (state == FILL) && bus.pmem_resp;
    bus.valid_in   = 1'b1;
  end

`ifdef L2CACHE_PERF_EN
  logic recheck;

  // The hit that follows a fill belongs to the miss already counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      recheck    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == FILL && bus.pmem_resp)
        recheck <= 1'b1;
      else if (state == TAG_CHECK)
        recheck <= 1'b0;

      if (state == TAG_CHECK && req) begin
        if (bus.hit_any) begin
          if (!recheck) hit_count <= hit_count + 1'b1;
        end else begin
          miss_count <= miss_count + 1'b1;
        end
      end

      if (state == WRITEBACK && bus.pmem_resp)
        wb_count <= wb_count + 1'b1;
    end
  end
`endif

endmodule
